truth_table_scanner: RTL and testbench

Sequential evaluator for the generated sum-of-products function modules. It sweeps every input combination of an N-variable combinational function, waits for the function output to settle, samples it, and streams the index of each true combination (minterm) out over a valid/ready interface. It sits around a generated `logic_function` instance in self-check and characterisation benches, and in on-chip BIST. It recovers the minterm list that the generated circuit was built from.

---
 rtl/tt_scan_pkg.sv | 17 +
 rtl/tt_settle_timer.sv | 36 +++
 rtl/truth_table_scanner.sv | 143 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_scan_pkg.sv
// Shared types and default constants for the truth-table scanner.
//   tt_state_t     : scanner FSM states
//   TT_N_VARS_DEF  : default number of function inputs
//   TT_SETTLE_DEF  : default settle cycles per vector
package tt_scan_pkg;

    localparam int unsigned TT_N_VARS_DEF = 12;
    localparam int unsigned TT_SETTLE_DEF = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each vector is held.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload with SETTLE_CYCLES-1 (has priority over en)
//   en         : decrement while nonzero
//   zero       : counter has reached 0 (decoded from the count register)
module tt_settle_timer
    import tt_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = TT_SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int unsigned W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [W-1:0] RELOAD = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] count;

    // Down-counter; holds at zero until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all input vectors of an N_VARS-input combinational function, samples
// its response after SETTLE_CYCLES, and streams the true vectors (minterms)
// out over a valid/ready interface in ascending order.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a scan (accepted in IDLE only)
//   busy, done    : scan in progress / one-cycle completion pulse
//   func_in       : vector driven to the function under evaluation
//   func_out      : function response to func_in
//   m_valid, m_ready, m_index : minterm stream
//   minterm_count : minterms emitted in the current or last scan
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int unsigned N_VARS        = TT_N_VARS_DEF,
    parameter int unsigned SETTLE_CYCLES = TT_SETTLE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_VARS-1:0] func_in,
    input  logic              func_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_VARS-1:0] m_index,
    output logic [N_VARS:0]   minterm_count
);

    localparam int unsigned CW = N_VARS + 1;

    tt_state_t state;
    tt_state_t state_next;

    logic zero;
    logic last;
    logic accept;
    logic handshake;
    logic advance;
    logic timer_load;
    logic timer_en;
    logic busy_d;
    logic done_d;
    logic m_valid_d;

    assign last = &func_in;

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .en   (timer_en),
        .zero (zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = SETTLE;
            end
            SETTLE: begin
                if (zero) begin
                    if (func_out)  state_next = EMIT;
                    else if (last) state_next = DONE;
                end
            end
            EMIT: begin
                if (m_ready) state_next = last ? DONE : SETTLE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control strobes and next values of the registered status outputs.
    always_comb begin
        accept     = (state == IDLE) && start;
        handshake  = (state == EMIT) && m_ready;
        // Step to the next vector after a rejected sample or an accepted minterm,
        // unless the all-ones vector was just finished.
        advance    = ((state == SETTLE) && zero && !func_out && !last) ||
                     (handshake && !last);
        timer_load = accept || advance;
        timer_en   = (state == SETTLE) && !zero;
        busy_d     = (state_next != IDLE);
        done_d     = (state_next == DONE);
        m_valid_d  = (state_next == EMIT);
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            busy    <= busy_d;
            done    <= done_d;
            m_valid <= m_valid_d;
        end
    end

    // Vector register and minterm counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_in       <= '0;
            minterm_count <= '0;
        end else begin
            if (accept) begin
                func_in <= '0;
            end else if (advance) begin
                func_in <= func_in + N_VARS'(1);
            end

            if (accept) begin
                minterm_count <= '0;
            end else if (handshake) begin
                minterm_count <= minterm_count + CW'(1);
            end
        end
    end

    // The presented index is the vector that produced it.
    assign m_index = func_in;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: a 12-input/settle-1 instance and a
// 4-input/settle-3 instance, driven by selectable reference functions.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic m_ready;
    int   sel;
    int   fsel;

    logic        busy12, done12, mv12, fo12;
    logic [11:0] fi12, mi12;
    logic [12:0] mc12;
    logic        busy4, done4, mv4, fo4;
    logic [3:0]  fi4, mi4;
    logic [4:0]  mc4;

    logic        start12, start4;
    logic        busy, done, mv;
    logic [11:0] fi, mi;
    logic [12:0] mc;

    bit rtab [4096];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    truth_table_scanner #(.N_VARS(12), .SETTLE_CYCLES(1)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .busy(busy12), .done(done12),
        .func_in(fi12), .func_out(fo12), .m_valid(mv12), .m_ready(m_ready),
        .m_index(mi12), .minterm_count(mc12)
    );

    truth_table_scanner #(.N_VARS(4), .SETTLE_CYCLES(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
        .func_in(fi4), .func_out(fo4), .m_valid(mv4), .m_ready(m_ready),
        .m_index(mi4), .minterm_count(mc4)
    );

    // Reference functions: 0 const-0, 1 six-vs-six equality, 2 const-1, 3 random table.
    function automatic logic fn(input int fs, input int n, input int idx);
        logic [11:0] v;
        v = 12'(idx);
        case (fs)
            0:       return 1'b0;
            1:       return (n == 12) ? (v[11:6] == v[5:0]) : (v[3:2] == v[1:0]);
            2:       return 1'b1;
            default: return rtab[idx];
        endcase
    endfunction

    always_comb begin
        fo12 = fn(fsel, 12, int'(fi12));
        fo4  = fn(fsel, 4, int'(fi4));
    end

    assign start12 = start && (sel == 0);
    assign start4  = start && (sel == 1);

    always_comb begin
        busy = (sel == 0) ? busy12 : busy4;
        done = (sel == 0) ? done12 : done4;
        mv   = (sel == 0) ? mv12   : mv4;
        fi   = (sel == 0) ? fi12   : 12'(fi4);
        mi   = (sel == 0) ? mi12   : 12'(mi4);
        mc   = (sel == 0) ? mc12   : 13'(mc4);
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int s;          // 0: 12-var/S=1 instance, 1: 4-var/S=3 instance
        int fs;         // reference function
        int rmode;      // 0 ready always, 1 random ready, 2 ten-cycle stall at index 65
        int poke;       // extra start pulses while busy and in the DONE cycle
        int exp_count;  // -1: take from the reference model
        int exp_done;   // -1: derive from cycle formula
    } scan_t;

    // One full scan with per-cycle checks and an end-of-scan comparison.
    task automatic run_scan(input scan_t t);
        int n, s_cyc, cyc, done_cyc, stall_left, nstall, exp_count, exp_done;
        logic prev_stall;
        logic [11:0] prev_idx;
        int exp_q[$];
        int got_q[$];
        int first_diff;

        sel  = t.s;
        fsel = t.fs;
        n     = (t.s == 0) ? 12 : 4;
        s_cyc = (t.s == 0) ? 1 : 3;
        for (int i = 0; i < (1 << n); i++) begin
            if (fn(t.fs, n, i)) exp_q.push_back(i);
        end
        exp_count = (t.exp_count >= 0) ? t.exp_count : exp_q.size();

        @(negedge clk);
        start      = 1'b1;
        m_ready    = 1'b1;
        cyc        = 1;
        done_cyc   = -1;
        stall_left = 10;
        nstall     = 0;
        prev_stall = 1'b0;
        prev_idx   = '0;

        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (t.poke != 0 && cyc == 100) start = 1'b1;
            if (cyc == 2) begin
                check("busy_after_accept", busy, 1);
                check("first_vector", fi, 0);
                check("count_cleared", mc, 0);
            end
            if (prev_stall) begin
                check("stall_valid_hold", mv, 1);
                check("stall_index_hold", mi, prev_idx);
            end
            if (mv) begin
                check("index_is_vector", mi, fi);
                check("count_live", mc, got_q.size());
            end
            if (done) begin
                done_cyc = cyc;
                check("busy_in_done", busy, 1);
                check("valid_low_in_done", mv, 0);
                if (t.poke != 0) start = 1'b1;
                break;
            end
            case (t.rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (mv && mi == 12'd65 && stall_left > 0) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            endcase
            if (mv && m_ready) got_q.push_back(int'(mi));
            if (mv && !m_ready) nstall++;
            prev_stall = mv && !m_ready;
            prev_idx   = mi;
        end

        exp_done = (t.exp_done >= 0) ? t.exp_done
                 : 2 + (1 << n) * s_cyc + exp_q.size() + nstall;
        if (done_cyc < 0) begin
            bad++;
            total++;
            $display("FAIL scan_timeout: no done after %0d cycles (sel=%0d fn=%0d)", cyc, t.s, t.fs);
        end else begin
            check("done_cycle", done_cyc, exp_done);
        end
        check("final_count", mc, exp_count);

        @(negedge clk);
        start   = 1'b0;
        m_ready = 1'b1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("vector_held_ones", fi, (1 << n) - 1);
        check("count_stable", mc, exp_count);

        first_diff = -1;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            if (first_diff < 0 && exp_q[k] != got_q[k]) first_diff = k;
        end
        check("minterm_list_len", got_q.size(), exp_q.size());
        if (first_diff >= 0)
            check("minterm_list_item", got_q[first_diff], exp_q[first_diff]);
        else
            check("minterm_list_item", 0, 0 * got_q.size());
    endtask

    scan_t tbl [6];

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b1;
        sel     = 0;
        fsel    = 0;
        for (int i = 0; i < 4096; i++) rtab[i] = 1'($urandom_range(0, 1));

        tbl[0] = '{s: 0, fs: 0, rmode: 0, poke: 0, exp_count: 0,  exp_done: 4098};
        tbl[1] = '{s: 0, fs: 1, rmode: 0, poke: 0, exp_count: 64, exp_done: 4162};
        tbl[2] = '{s: 0, fs: 1, rmode: 2, poke: 0, exp_count: 64, exp_done: 4172};
        tbl[3] = '{s: 1, fs: 2, rmode: 0, poke: 1, exp_count: 16, exp_done: 66};
        tbl[4] = '{s: 1, fs: 3, rmode: 1, poke: 0, exp_count: -1, exp_done: -1};
        tbl[5] = '{s: 0, fs: 3, rmode: 1, poke: 1, exp_count: -1, exp_done: -1};

        repeat (3) @(negedge clk);
        check("rst_busy", busy12, 0);
        check("rst_done", done12, 0);
        check("rst_valid", mv12, 0);
        check("rst_func_in", fi12, 0);
        check("rst_index", mi12, 0);
        check("rst_count", mc12, 0);
        check("rst_busy4", busy4, 0);
        check("rst_count4", mc4, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_scan(tbl[i]);

        // Reset in the middle of a scan, at vector 0x800.
        sel  = 0;
        fsel = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 5000 && fi12 != 12'h800; c++) @(negedge clk);
        check("reached_0x800", fi12, 12'h800);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy12, 0);
        check("midrst_done", done12, 0);
        check("midrst_valid", mv12, 0);
        check("midrst_func_in", fi12, 0);
        check("midrst_index", mi12, 0);
        check("midrst_count", mc12, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy12, 0);

        run_scan('{s: 0, fs: 1, rmode: 0, poke: 1, exp_count: 64, exp_done: 4162});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
